imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
Shares one single-port synchronous instruction RAM between two requesters. The CPU fetch unit is the primary requester. The host/test loader programs and inspects instructions. The block sits between both requesters and the RAM macro and arbitrates per cycle. Fixed CPU priority applies, with a starvation guard for the host. Out-of-range accesses read as zero, matching the fetch harness convention.

Parameters:
MEM_DEPTH, 64, number of 32-bit words; valid addresses are 0..MEM_DEPTH-1.
STARVE_LIMIT, 8, consecutive denied host-request cycles before the host is forced through for one cycle (legal range >=1).
CNT_W, 4, width of the starvation counter (must satisfy 2^CNT_W > STARVE_LIMIT).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU fetch request (read only)
cpu_addr  in  16  CPU word address
cpu_gnt  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid (registered)
cpu_rdata  out  32  fetched instruction
host_req  in  1  host request
host_we  in  1  1=write, 0=read
host_addr  in  16  host word address
host_wdata  in  32  host write data
host_gnt  out  1  host request accepted this cycle (combinational)
host_rvalid  out  1  host_rdata valid (registered)
host_rdata  out  32  host read data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  16  RAM address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (async, while rst=1): starve_cnt=0, state=CPU_PRI, owner_q=NONE, cpu_rvalid=0, host_rvalid=0, cpu_rdata=0, host_rdata=0. mem_en, mem_we, cpu_gnt and host_gnt are forced 0 while rst is high.
- States: CPU_PRI (default) and HOST_FORCE.
- In CPU_PRI: if cpu_req=1, grant the CPU; otherwise grant the host if host_req=1.
- In HOST_FORCE: if host_req=1, grant the host; otherwise grant the CPU if cpu_req=1.
- State transitions:
  - CPU_PRI->HOST_FORCE when host_req=1 and the host is denied and starve_cnt+1==STARVE_LIMIT.
  - HOST_FORCE->CPU_PRI after any single cycle in HOST_FORCE.
- starve_cnt:
  - Increments on each cycle with host_req=1 and host_gnt=0.
  - Clears on host grant, or when host_req=0.
  - Saturates at STARVE_LIMIT.
- Exactly one grant per cycle at most. A requester holds req and addr until gnt is seen. There is no queuing.
- Granted in-range access (addr<MEM_DEPTH): mem_en=1 that cycle, and mem_addr/mem_we/mem_wdata come from the winner. CPU accesses always drive mem_we=0.
- Granted out-of-range access: mem_en=0. A write is dropped silently. A read still completes, returning rdata=0.
- Read latency is 1 cycle. A read granted in cycle N gives the owner's rvalid=1 in cycle N+1, with rdata=mem_rdata, or 0 if out of range.
  - owner_q registers the read owner and the range flag.
  - rvalid is a single-cycle pulse.
  - rdata holds its last value until the next read completes.
- A host write produces no host_rvalid. The write is committed at the grant-cycle edge. A same-address read granted in N+1 returns the new data.
- Back-to-back grants to either requester are allowed every cycle, giving full throughput of 1 access/cycle.
- When no request is granted, mem_en=0, mem_we=0, and mem_addr/mem_wdata are 0.
- Reset asserted mid-read: the pending rvalid is discarded and never asserted after reset deasserts. Memory contents are unaffected.

Test Plan:
- Reset check: hold rst=1 with both reqs high -> all gnt/rvalid/mem_en=0. Release -> first cycle grants the CPU.
- CPU fetch stream: cpu_req=1, addrs 0,1,2 on consecutive cycles with RAM preloaded with 0xA0000000+addr -> cpu_gnt=1 each cycle; cpu_rvalid=1 in cycles +1..+3 with data 0xA0000000, 0xA0000001, 0xA0000002.
- Host write then CPU read: host writes 0xDEADBEEF to addr 5 in cycle N (CPU idle); CPU reads addr 5 in N+1 -> cpu_rdata=0xDEADBEEF in N+2; no host_rvalid is ever asserted.
- Starvation: STARVE_LIMIT=4, cpu_req and host_req held high -> host_gnt=1 exactly on cycles 5, 10, 15 (every 5th cycle); the CPU is granted on all others.
- Out of range: CPU reads addr 64 and host writes addr 100 (MEM_DEPTH=64) -> mem_en=0 both cycles; cpu_rvalid=1 with cpu_rdata=0; a subsequent read of addr 36 returns its unchanged preload value.
- Reset mid-read: grant a CPU read in cycle N, pulse rst in N+1 (asynchronously, mid-cycle) -> cpu_rvalid stays 0, starve_cnt=0, state CPU_PRI.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares one single-port synchronous instruction RAM between the CPU fetch unit and the host loader.
// Fixed CPU priority with a host starvation guard; reads return one cycle after grant, out-of-range reads return zero.
module imem_port_arbiter #(
    parameter int MEM_DEPTH    = 64,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        CPU_PRI,
        HOST_FORCE
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_HOST
    } owner_e;

    localparam logic [31:0]      DEPTH_U = MEM_DEPTH;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    owner_e            owner_q, owner_d;
    logic              inr_q, inr_d;
    logic [31:0]       cpu_rdata_q;
    logic [31:0]       host_rdata_q;

    logic              cpu_inr;
    logic              host_inr;
    logic [31:0]       ret_dat;

    assign cpu_inr  = {16'd0, cpu_addr}  < DEPTH_U;
    assign host_inr = {16'd0, host_addr} < DEPTH_U;

    always_comb begin
        cpu_gnt   = 1'b0;
        host_gnt  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'd0;
        mem_wdata = 32'd0;
        state_d   = state_q;
        starve_d  = starve_q;
        owner_d   = OWN_NONE;
        inr_d     = 1'b0;

        if (!rst) begin
            if (state_q == HOST_FORCE) begin
                host_gnt = host_req;
                cpu_gnt  = cpu_req && !host_req;
            end else begin
                cpu_gnt  = cpu_req;
                host_gnt = host_req && !cpu_req;
            end
        end

        // Out-of-range winners never touch the RAM, but reads still return (as zero).
        if (host_gnt) begin
            if (host_inr) begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            if (!host_we) begin
                owner_d = OWN_HOST;
                inr_d   = host_inr;
            end
        end else if (cpu_gnt) begin
            if (cpu_inr) begin
                mem_en   = 1'b1;
                mem_addr = cpu_addr;
            end
            owner_d = OWN_CPU;
            inr_d   = cpu_inr;
        end

        if (host_req && !host_gnt) begin
            if (starve_q != LIMIT) begin
                starve_d = starve_q + 1'b1;
            end
            if (state_q == CPU_PRI && (starve_q + 1'b1) == LIMIT) begin
                state_d = HOST_FORCE;
            end
        end else begin
            starve_d = '0;
        end

        if (state_q == HOST_FORCE) begin
            state_d = CPU_PRI;
        end
    end

    assign ret_dat     = inr_q ? mem_rdata : 32'd0;
    assign cpu_rvalid  = (owner_q == OWN_CPU);
    assign host_rvalid = (owner_q == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? ret_dat : cpu_rdata_q;
    assign host_rdata  = host_rvalid ? ret_dat : host_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CPU_PRI;
            starve_q     <= '0;
            owner_q      <= OWN_NONE;
            inr_q        <= 1'b0;
            cpu_rdata_q  <= 32'd0;
            host_rdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            inr_q    <= inr_d;
            if (cpu_rvalid) begin
                cpu_rdata_q <= ret_dat;
            end
            if (host_rvalid) begin
                host_rdata_q <= ret_dat;
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, hand-written corner sequences and a randomized run
// against a transaction-level reference model with a synchronous RAM model attached to the memory port.
module tb_imem_port_arbiter;

    localparam int DEPTH = 64;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .MEM_DEPTH   (DEPTH),
        .STARVE_LIMIT(LIMIT),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port synchronous RAM
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_rdata = 32'd0;
    assign mem_rdata = ram_rdata;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
            else        ram_rdata <= ram[mem_addr[5:0]];
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {cpu_gnt, host_gnt, mem_en, mem_we, cpu_rvalid, host_rvalid}
    function automatic logic [5:0] flags();
        return {cpu_gnt, host_gnt, mem_en, mem_we & mem_en, cpu_rvalid, host_rvalid};
    endfunction

    task automatic drive(input logic cr, input logic [15:0] ca, input logic hr, input logic hw,
                         input logic [15:0] ha, input logic [31:0] hd);
        cpu_req    = cr;
        cpu_addr   = ca;
        host_req   = hr;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
    endtask

    typedef struct {
        logic        cr;
        logic [15:0] ca;
        logic        hr;
        logic        hw;
        logic [15:0] ha;
        logic [31:0] hd;
        logic [5:0]  ef;
        logic [31:0] ecd;
        logic [31:0] ehd;
        logic [15:0] ea;
    } vec_t;

    function automatic vec_t mk(input logic cr, input logic [15:0] ca, input logic hr, input logic hw,
                                input logic [15:0] ha, input logic [31:0] hd, input logic [5:0] ef,
                                input logic [31:0] ecd, input logic [31:0] ehd, input logic [15:0] ea);
        vec_t v;
        v.cr = cr; v.ca = ca; v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.ef = ef; v.ecd = ecd; v.ehd = ehd; v.ea = ea;
        return v;
    endfunction

    vec_t tbl [15];

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          denied;
    int          pend_own;     // 0 none, 1 cpu, 2 host
    logic        pend_inr;
    logic [15:0] pend_addr;
    logic [31:0] exp_crd, exp_hrd;

    initial begin
        logic        hfirst, g_cpu, g_host, inr, e_en, e_we;
        logic [15:0] e_addr;
        logic        e_cv, e_hv;
        logic [5:0]  ef;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'hA000_0000 + i;
            ref_mem[i] = 32'hA000_0000 + i;
        end

        // Reset holds everything quiet even with both requesters asking
        rst = 1'b1;
        drive(1'b1, 16'd9, 1'b1, 1'b0, 16'd3, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_quiet", {mem_addr != 16'd0 && mem_en, flags(), cpu_rdata, host_rdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", flags(), 6'b101000);
        @(posedge clk); #1;
        drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 32'd0);
        @(posedge clk); #1;

        tbl[0]  = mk(1, 16'd0,  0, 0, 16'd0,   32'd0,        6'b101000, 32'hA000_0009, 32'd0,         16'd0);
        tbl[1]  = mk(1, 16'd1,  0, 0, 16'd0,   32'd0,        6'b101010, 32'hA000_0000, 32'd0,         16'd1);
        tbl[2]  = mk(1, 16'd2,  0, 0, 16'd0,   32'd0,        6'b101010, 32'hA000_0001, 32'd0,         16'd2);
        tbl[3]  = mk(0, 16'd0,  0, 0, 16'd0,   32'd0,        6'b000010, 32'hA000_0002, 32'd0,         16'd0);
        tbl[4]  = mk(0, 16'd0,  1, 1, 16'd5,   32'hDEADBEEF, 6'b011100, 32'hA000_0002, 32'd0,         16'd5);
        tbl[5]  = mk(1, 16'd5,  0, 0, 16'd0,   32'd0,        6'b101000, 32'hA000_0002, 32'd0,         16'd5);
        tbl[6]  = mk(0, 16'd0,  0, 0, 16'd0,   32'd0,        6'b000010, 32'hDEADBEEF,  32'd0,         16'd0);
        tbl[7]  = mk(1, 16'd64, 0, 0, 16'd0,   32'd0,        6'b100000, 32'hDEADBEEF,  32'd0,         16'd0);
        tbl[8]  = mk(0, 16'd0,  1, 1, 16'd100, 32'h1234_5678, 6'b010010, 32'd0,        32'd0,         16'd0);
        tbl[9]  = mk(1, 16'd36, 0, 0, 16'd0,   32'd0,        6'b101000, 32'd0,         32'd0,         16'd36);
        tbl[10] = mk(0, 16'd0,  1, 0, 16'd36,  32'd0,        6'b011010, 32'hA000_0024, 32'd0,         16'd36);
        tbl[11] = mk(0, 16'd0,  0, 0, 16'd0,   32'd0,        6'b000001, 32'hA000_0024, 32'hA000_0024, 16'd0);
        tbl[12] = mk(1, 16'd3,  1, 0, 16'd7,   32'd0,        6'b101000, 32'hA000_0024, 32'hA000_0024, 16'd3);
        tbl[13] = mk(0, 16'd0,  1, 0, 16'd7,   32'd0,        6'b011010, 32'hA000_0003, 32'hA000_0024, 16'd7);
        tbl[14] = mk(0, 16'd0,  0, 0, 16'd0,   32'd0,        6'b000001, 32'hA000_0003, 32'hA000_0007, 16'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].cr, tbl[i].ca, tbl[i].hr, tbl[i].hw, tbl[i].ha, tbl[i].hd);
            @(negedge clk);
            check($sformatf("tbl%0d", i),
                  {flags(), cpu_rdata, host_rdata, mem_en ? mem_addr : 16'd0},
                  {tbl[i].ef, tbl[i].ecd, tbl[i].ehd, tbl[i].ef[3] ? tbl[i].ea : 16'd0});
            @(posedge clk); #1;
        end

        // Starvation: both held, host forced through every (LIMIT+1)th cycle
        drive(1'b1, 16'd1, 1'b1, 1'b0, 16'd2, 32'd0);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check($sformatf("starve_c%0d", c), {cpu_gnt, host_gnt},
                  (c % (LIMIT + 1) == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
        end

        // Reset mid-read: pending CPU read must vanish, starvation history must clear
        drive(1'b1, 16'd10, 1'b1, 1'b0, 16'd11, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("pre_rst_gnt", {cpu_gnt, host_gnt}, 2'b10);
            @(posedge clk);
        end
        #3 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_quiet", flags(), 6'b000000);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after", {cpu_gnt, host_gnt, cpu_rvalid}, 3'b100);
        for (int c = 2; c <= LIMIT + 1; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("rst_starve_c%0d", c), {cpu_gnt, host_gnt},
                  (c == LIMIT + 1) ? 2'b01 : 2'b10);
        end
        @(posedge clk); #1;

        // Randomized run against the reference model
        drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[5] = 32'hDEADBEEF;
        denied   = 0;
        pend_own = 0;
        pend_inr = 1'b0;
        pend_addr = 16'd0;
        exp_crd  = 32'd0;
        exp_hrd  = 32'd0;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            hfirst = (denied >= LIMIT);
            g_host = host_req && (hfirst || !cpu_req);
            g_cpu  = cpu_req && !g_host;
            inr    = g_host ? (int'(host_addr) < DEPTH) : (int'(cpu_addr) < DEPTH);
            e_en   = (g_cpu || g_host) && inr;
            e_we   = g_host && host_we && inr;
            e_addr = g_host ? host_addr : cpu_addr;
            e_cv   = (pend_own == 1);
            e_hv   = (pend_own == 2);
            if (e_cv) exp_crd = pend_inr ? ref_mem[pend_addr[5:0]] : 32'd0;
            if (e_hv) exp_hrd = pend_inr ? ref_mem[pend_addr[5:0]] : 32'd0;
            ef = {g_cpu, g_host, e_en, e_we, e_cv, e_hv};
            check($sformatf("rand%0d", n),
                  {flags(), cpu_rdata, host_rdata, mem_en ? mem_addr : 16'd0, (mem_en && mem_we) ? mem_wdata : 32'd0},
                  {ef, exp_crd, exp_hrd, e_en ? e_addr : 16'd0, e_we ? host_wdata : 32'd0});

            @(posedge clk);
            if (e_we) ref_mem[host_addr[5:0]] = host_wdata;
            pend_own  = (g_cpu) ? 1 : (g_host && !host_we) ? 2 : 0;
            pend_inr  = inr;
            pend_addr = e_addr;
            denied    = (host_req && !g_host) ? denied + 1 : 0;
            #1;
            if (!(cpu_req && !g_cpu)) begin
                cpu_req  = ($urandom_range(0, 99) < 70);
                cpu_addr = 16'($urandom_range(0, 79));
            end
            if (!(host_req && !g_host)) begin
                host_req   = ($urandom_range(0, 99) < 50);
                host_we    = $urandom_range(0, 1) == 1;
                host_addr  = 16'($urandom_range(0, 79));
                host_wdata = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
